// File: rtl/instruction_execute.sv
// instruction_execute: execute stage and architectural state (A/B/C, ip) of the 3-bit machine.
// Optional feature macro: EXEC_STEP_LIMIT_EN (retired-instruction limit of MAX_STEPS).
`default_nettype none

module instruction_execute #(
  parameter int REG_W     = 32,
  parameter int MAX_STEPS = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [REG_W-1:0] a_init,
  input  logic [REG_W-1:0] b_init,
  input  logic [REG_W-1:0] c_init,
  input  logic [4:0]       prog_len,
  input  logic [2:0]       opcode,
  input  logic [2:0]       operand,
  input  logic             out_ready,
  output logic [3:0]       instr_ptr,
  output logic             halt,
  output logic             out_valid,
  output logic [2:0]       out_data,
  output logic             done,
  output logic             err,
  output logic [REG_W-1:0] reg_a,
  output logic [REG_W-1:0] reg_b,
  output logic [REG_W-1:0] reg_c
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [REG_W-1:0] SHIFT_LIM = REG_W'(REG_W);

  state_t           state_q, state_d;
  logic [3:0]       ip_q, ip_d;
  logic [4:0]       len_q, len_d;
  logic [REG_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic             halt_q, halt_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       out_data_q, out_data_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [REG_W-1:0] combo;
  logic [REG_W-1:0] a_shr;
  logic             uses_combo;
  logic             combo_err;

  always_comb begin
    combo = '0;
    case (operand)
      3'd4:    combo = a_q;
      3'd5:    combo = b_q;
      3'd6:    combo = c_q;
      3'd7:    combo = '0;
      default: combo = REG_W'(operand);
    endcase
  end

  // Oversized shift amounts are clamped explicitly to a zero result.
  assign a_shr      = (combo >= SHIFT_LIM) ? '0 : (a_q >> combo);
  assign uses_combo = (opcode == 3'd0) || (opcode == 3'd2) || (opcode >= 3'd5);
  assign combo_err  = uses_combo && (operand == 3'd7);

`ifdef EXEC_STEP_LIMIT_EN
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              retire;
  logic              limit_hit;

  assign retire    = ((state_q == S_EXEC) && !combo_err && (opcode != 3'd5)) ||
                     ((state_q == S_OUT) && out_ready);
  assign limit_hit = ((steps_q + STEP_W'(1)) == STEP_W'(MAX_STEPS));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) steps_q <= '0;
    else       steps_q <= steps_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    len_d       = len_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = done_q;
    err_d       = err_q;
`ifdef EXEC_STEP_LIMIT_EN
    steps_d     = steps_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a_init;
          b_d     = b_init;
          c_d     = c_init;
          len_d   = prog_len;
          ip_d    = 4'd0;
          done_d  = 1'b0;
          err_d   = 1'b0;
`ifdef EXEC_STEP_LIMIT_EN
          steps_d = '0;
`endif
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (({1'b0, ip_q} + 5'd1) >= len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (combo_err) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = S_FETCH;
          ip_d    = ip_q + 4'd2;
          case (opcode)
            3'd0: a_d = a_shr;
            3'd1: b_d = b_q ^ REG_W'(operand);
            3'd2: b_d = REG_W'(combo[2:0]);
            3'd3: if (a_q != '0) ip_d = {1'b0, operand};
            3'd4: b_d = b_q ^ c_q;
            3'd5: begin
              out_data_d  = combo[2:0];
              out_valid_d = 1'b1;
              ip_d        = ip_q;
              state_d     = S_OUT;
            end
            3'd6: b_d = a_shr;
            default: c_d = a_shr;
          endcase
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          ip_d        = ip_q + 4'd2;
          state_d     = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef EXEC_STEP_LIMIT_EN
    if (retire) begin
      steps_d = steps_q + STEP_W'(1);
      if (limit_hit) begin
        state_d = S_DONE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end
    end
`endif
    halt_d = (state_d == S_IDLE) || (state_d == S_OUT) || (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      ip_q        <= 4'd0;
      len_q       <= 5'd0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      halt_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 3'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      len_q       <= len_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      halt_q      <= halt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign instr_ptr = ip_q;
  assign halt      = halt_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign reg_a     = a_q;
  assign reg_b     = b_q;
  assign reg_c     = c_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_execute.sv
// tb_instruction_execute: directed and random programs checked against a behavioural interpreter.
`default_nettype none

module tb_instruction_execute;

  localparam int REG_W = 32;
`ifdef EXEC_STEP_LIMIT_EN
  localparam int MAXS  = 8;
  localparam bit LIMIT = 1'b1;
`else
  localparam int MAXS  = 1024;
  localparam bit LIMIT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [REG_W-1:0] a_init = '0, b_init = '0, c_init = '0;
  logic [4:0]       prog_len = '0;
  logic [2:0]       opcode = '0, operand = '0;
  logic             out_ready = 1'b0;
  logic [3:0]       instr_ptr;
  logic             halt, out_valid, done, err;
  logic [2:0]       out_data;
  logic [REG_W-1:0] reg_a, reg_b, reg_c;

  instruction_execute #(.REG_W(REG_W), .MAX_STEPS(MAXS)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .a_init(a_init), .b_init(b_init), .c_init(c_init), .prog_len(prog_len),
    .opcode(opcode), .operand(operand), .out_ready(out_ready),
    .instr_ptr(instr_ptr), .halt(halt), .out_valid(out_valid), .out_data(out_data),
    .done(done), .err(err), .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c)
  );

  always #5 clk = ~clk;

  logic [2:0] prog_mem [16];

  // Fetch stage stand-in: registered read of program[ip] and program[ip+1].
  always_ff @(posedge clk) begin
    if (!halt) begin
      opcode  <= prog_mem[instr_ptr];
      operand <= prog_mem[instr_ptr + 4'd1];
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference interpreter results
  int          m_out[$];
  logic [31:0] m_a, m_b, m_c;
  bit          m_err;
  int          m_k, m_o, m_reason;
  int          g_out[$];

  function automatic logic [31:0] shr(input logic [31:0] v, input logic [31:0] amt);
    return (amt >= 32) ? 32'd0 : (v >> amt);
  endfunction

  task automatic model(input logic [31:0] a, b, c, input int len, output bit ok);
    int ip, op, opd, ipn;
    logic [31:0] cb;
    ip = 0; m_out.delete(); m_err = 0; m_k = 0; m_o = 0; m_reason = 0; ok = 0;
    for (int it = 0; it < 300; it++) begin
      if (ip + 1 >= len) begin ok = 1; m_reason = 0; break; end
      op  = int'(prog_mem[ip]);
      opd = int'(prog_mem[(ip + 1) % 16]);
      cb  = (opd < 4) ? 32'(opd) : (opd == 4) ? a : (opd == 5) ? b : (opd == 6) ? c : 32'd0;
      if (opd == 7 && (op == 0 || op == 2 || op >= 5)) begin
        ok = 1; m_err = 1; m_reason = 1; break;
      end
      ipn = (ip + 2) % 16;
      case (op)
        0: a = shr(a, cb);
        1: b = b ^ 32'(opd);
        2: b = cb % 8;
        3: if (a != 0) ipn = opd;
        4: b = b ^ c;
        5: m_out.push_back(int'(cb % 8));
        6: b = shr(a, cb);
        default: c = shr(a, cb);
      endcase
      ip = ipn;
      if (op == 5) m_o++; else m_k++;
      if (LIMIT && (m_k + m_o == MAXS)) begin ok = 1; m_err = 1; m_reason = 2; break; end
    end
    m_a = a; m_b = b; m_c = c;
  endtask

  task automatic run_prog(input logic [31:0] a, b, c, input int len, input int mode, input string nm);
    bit ok, rdy, pv, pr;
    logic [2:0] pd;
    int n, exp_cyc;
    model(a, b, c, len, ok);
    g_out.delete();
    @(negedge clk);
    a_init = a; b_init = b; c_init = c; prog_len = 5'(len); start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; n = 1; pv = 0; pr = 0; pd = 0;
    while (!done && n < 3000) begin
      if (pv && !pr) begin
        check({nm, "_hold_valid"}, out_valid, 1);
        check({nm, "_hold_data"}, out_data, pd);
      end
      if (out_valid) check({nm, "_halt_in_out"}, halt, 1);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((n / 3) % 2) : 1'($urandom % 2);
      out_ready = rdy;
      if (out_valid && rdy) g_out.push_back(int'(out_data));
      pv = out_valid; pr = rdy; pd = out_data;
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    check({nm, "_done"}, done, 1);
    check({nm, "_nout"}, g_out.size(), m_out.size());
    for (int i = 0; i < m_out.size() && i < g_out.size(); i++)
      check({nm, "_out"}, g_out[i], m_out[i]);
    check({nm, "_A"}, reg_a, m_a);
    check({nm, "_B"}, reg_b, m_b);
    check({nm, "_C"}, reg_c, m_c);
    check({nm, "_err"}, err, m_err);
    check({nm, "_halt_done"}, halt, 1);
    if (mode == 0) begin
      exp_cyc = 2 * m_k + 3 * m_o + ((m_reason == 0) ? 2 : (m_reason == 1) ? 3 : 1);
      check({nm, "_cycles"}, n, exp_cyc);
    end
  endtask

  task automatic load(input int len, input int w0, w1, w2, w3, w4, w5);
    int w[6];
    w = '{w0, w1, w2, w3, w4, w5};
    for (int i = 0; i < 16; i++) prog_mem[i] = 3'($urandom);
    for (int i = 0; i < len && i < 6; i++) prog_mem[i] = 3'(w[i]);
  endtask

  initial begin
    int ref1[10];
    bit ok;
    int runs, tries, len;
    logic [31:0] ra, rb, rc;
    ref1 = '{4, 6, 3, 5, 6, 3, 5, 2, 1, 0};
    for (int i = 0; i < 16; i++) prog_mem[i] = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_halt", halt, 1);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ip", instr_ptr, 0);
    check("rst_regs", {reg_a, reg_b} | 64'(reg_c), 0);
    rstn = 1'b1;

    load(6, 0, 1, 5, 4, 3, 0);
    run_prog(729, 0, 0, 6, 0, "t729");
    check("t729_n", g_out.size(), 10);
    for (int i = 0; i < 10 && i < g_out.size(); i++) check("t729_seq", g_out[i], ref1[i]);
    if (!LIMIT) check("t729_Afin", reg_a, 0);

    load(2, 2, 6, 0, 0, 0, 0);
    run_prog(0, 0, 9, 2, 0, "bst");
    check("bst_B", reg_b, 1);

    load(2, 1, 7, 0, 0, 0, 0);
    run_prog(0, 29, 0, 2, 0, "bxl");
    check("bxl_B", reg_b, 26);

    load(2, 4, 0, 0, 0, 0, 0);
    run_prog(0, 2024, 43690, 2, 0, "bxc");
    check("bxc_B", reg_b, 44354);

    load(6, 5, 0, 5, 1, 5, 4);
    run_prog(10, 0, 0, 6, 1, "stall");

    load(2, 2, 7, 0, 0, 0, 0);
    run_prog(0, 77, 0, 2, 0, "c7");
    check("c7_err", err, 1);
    check("c7_B", reg_b, 77);

    if (LIMIT) begin
      load(2, 3, 0, 0, 0, 0, 0);
      run_prog(1, 0, 0, 2, 0, "limit");
      check("limit_err", err, 1);
    end

    // Reset while an output is pending
    load(2, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    a_init = 10; prog_len = 5'd2; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("rr_reached_out", out_valid, 1);
    rstn = 1'b0;
    #1;
    check("rr_valid", out_valid, 0);
    check("rr_halt", halt, 1);
    check("rr_data", out_data, 0);
    check("rr_ip", instr_ptr, 0);
    check("rr_done_err", {done, err}, 0);
    @(negedge clk);
    rstn = 1'b1;

    runs = 0;
    tries = 0;
    while (runs < 40 && tries < 400) begin
      tries++;
      len = $urandom_range(2, 16);
      for (int i = 0; i < 16; i++) prog_mem[i] = 3'($urandom);
      ra = $urandom >> $urandom_range(0, 31);
      rb = $urandom;
      rc = $urandom >> $urandom_range(0, 31);
      model(ra, rb, rc, len, ok);
      if (ok) begin
        run_prog(ra, rb, rc, len, runs % 3, "rnd");
        runs++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_execute.md
# instruction_execute

Execute stage and architectural state of the 3-bit machine. Consumes the registered `opcode`/`operand` pair from the fetch stage and owns registers A, B and C and the instruction pointer. It also drives `instr_ptr` and `halt` back into fetch and emits 3-bit output values through a valid/ready handshake. One instruction retires every two cycles, longer when output back-pressure stalls it.

## Interface
- `REG_W`, 32: width of registers A, B, C and of the `*_init` inputs (min 8).
- `MAX_STEPS`, 1024: retired-instruction limit; used only with `EXEC_STEP_LIMIT_EN`.
- `clk` in 1: single clock; all state on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start` in 1: begin run; honoured only in IDLE or DONE.
- `a_init`, `b_init`, `c_init` in REG_W: register values loaded on accepted `start`.
- `prog_len` in 5: program length in 3-bit words, 0..16; sampled on accepted `start`.
- `opcode` in 3: from fetch; word at `instr_ptr`.
- `operand` in 3: from fetch; word at `instr_ptr+1`.
- `out_ready` in 1: downstream accepts `out_data`.
- `instr_ptr` out 4: current instruction pointer, to fetch.
- `halt` out 1: freezes fetch.
- `out_valid` out 1: `out_data` valid.
- `out_data` out 3: output value.
- `done` out 1: run finished; held until next `start`.
- `err` out 1: run ended on reserved combo operand 7, or on the step limit.
- `reg_a`, `reg_b`, `reg_c` out REG_W: architectural registers, for observation.

## Operation
- States: IDLE, FETCH, EXEC, OUT, DONE.
- Reset: state IDLE, `instr_ptr`=0, A=B=C=0, `halt`=1, `out_valid`=0, `out_data`=0, `done`=0, `err`=0, step counter=0.
- IDLE/DONE + `start`:
  - load A/B/C from `*_init` and latch `prog_len`;
  - `instr_ptr`=0; clear `done`, `err`, step counter;
  - go to FETCH.
- FETCH: `halt`=0 so fetch latches `program[ip]` and `program[ip+1]` this edge.
  - If `ip+1 >= prog_len` (5-bit compare, no wrap), go to DONE with `done`=1.
  - Otherwise go to EXEC.
- EXEC: `halt`=0. Decode `opcode`.
  - Literal = `operand`.
  - Combo operand: 0-3 give the literal; 4 gives A, 5 gives B, 6 gives C.
  - Combo 7 is used only where a combo operand is consumed. It sets `err`=1, goes to DONE with `done`=1, and leaves registers unchanged.
- Opcodes:
  - 0 adv: A = A >> combo.
  - 1 bxl: B = B ^ literal (zero-extended).
  - 2 bst: B = combo & 7.
  - 3 jnz: if A != 0, ip = literal; else ip += 2.
  - 4 bxc: B = B ^ C; operand ignored.
  - 5 out: `out_data` = combo & 7, `out_valid` = 1, go to OUT.
  - 6 bdv: B = A >> combo.
  - 7 cdv: C = A >> combo.
- Shift rule: a shift amount >= REG_W yields 0. Shifts are logical and unsigned.
- Instruction pointer:
  - All opcodes except jnz-taken and out do ip += 2 at the end of EXEC and go to FETCH.
  - ip arithmetic is 4-bit and wraps mod 16. The FETCH bound check catches overrun.
- OUT: `halt`=1, `out_valid` held and `out_data` stable.
  - On a cycle with `out_ready`=1: `out_valid`=0 next edge, ip += 2, go to FETCH.
- DONE: `halt`=1, `done`=1. Registers, ip and `err` are held.
- `start` in FETCH, EXEC or OUT is ignored.

## Timing
- `start` edge to first FETCH: 1 cycle. Non-out instruction: 2 cycles (FETCH + EXEC).
- `out`: minimum 3 cycles. `out_valid` rises at the end of EXEC and lasts >= 1 cycle; the transfer happens on the first cycle with `out_valid & out_ready`.
- `out_ready` is ignored outside OUT. Holding `out_ready` high continuously yields exactly one-cycle `out_valid` pulses.
- `done` rises one edge after the FETCH cycle that fails the bound check, or after the erroring EXEC.
- `halt` is a registered output: high exactly in IDLE, OUT and DONE.
- Async reset mid-run (any state, including OUT with `out_valid`=1) returns to reset values immediately. No output transfer completes on that edge.

## Configuration
- `EXEC_STEP_LIMIT_EN` defined:
  - The counter increments at each retired instruction (end of EXEC, or OUT acceptance for out).
  - When it reaches `MAX_STEPS`, go to DONE with `done`=1 and `err`=1 instead of FETCH.
- Not defined: no counter is built and runs are unbounded. `MAX_STEPS` is unused.

## Test plan
- A=729, B=0, C=0, program 0,1,5,4,3,0 (`prog_len`=6), `out_ready`=1 -> outputs 4,6,3,5,6,3,5,2,1,0, then `done`=1, A=0, `err`=0.
- C=9, program 2,6 -> B=1, `done` after 4 cycles from `start`, no `out_valid`.
- B=29, program 1,7 -> B=26. B=2024 and C=43690, program 4,0 -> B=44354.
- A=10, program 5,0,5,1,5,4 with `out_ready` toggling 0/1 every 3 cycles -> outputs 0,1,2 in order, no duplicates or drops, `out_data` stable while stalled.
- Program 2,7 -> `err`=1, `done`=1, B unchanged. Reset asserted during OUT -> all outputs at reset values, `halt`=1.
- With `EXEC_STEP_LIMIT_EN`, `MAX_STEPS`=8: A=1, program 3,0 (infinite loop) -> `done`=1 and `err`=1 after 8 retirements.
